// File: rtl/clk_div_prog.sv
// Multi-channel programmable clock/tick generator. Each channel divides clk by a run-time
// divisor in toggle (square wave) or pulse mode; new settings take effect at terminal count.
module clk_div_prog #(
    parameter int NCH         = 2,
    parameter int CNT_W       = 32,
    parameter int DIV_DEFAULT = 50000000,
    parameter int CH_W        = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sync,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic             cfg_mode,
    output logic [NCH-1:0]   cfg_pend,
    output logic [NCH-1:0]   clk_out,
    output logic [NCH-1:0]   tick
);

    localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DIV_DEFAULT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    logic [CNT_W-1:0] cnt    [NCH];
    logic [CNT_W-1:0] divAct [NCH];
    logic [CNT_W-1:0] divShd [NCH];
    logic [NCH-1:0]   modeAct;
    logic [NCH-1:0]   modeShd;
    logic [NCH-1:0]   pend;
    logic [NCH-1:0]   clkReg;
    logic [NCH-1:0]   tickReg;

    logic [NCH-1:0]   wrSel;
    logic [NCH-1:0]   atTc;

    // Out-of-range channel indices match no channel, so such writes are dropped.
    always_comb begin
        wrSel = '0;
        atTc  = '0;
        for (int i = 0; i < NCH; i++) begin
            wrSel[i] = cfg_we && (int'(cfg_ch) == i);
            atTc[i]  = en && (cnt[i] == divAct[i]);
        end
    end

    // NOTE: the per-channel arrays are plain flops, not RAM, so every element is reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (reset) begin
                cnt[i]     <= CNT_ZERO;
                divAct[i]  <= DIV_RST;
                divShd[i]  <= DIV_RST;
                modeAct[i] <= 1'b0;
                modeShd[i] <= 1'b0;
                pend[i]    <= 1'b0;
                clkReg[i]  <= 1'b0;
                tickReg[i] <= 1'b0;
            end else begin
                if (wrSel[i]) begin
                    divShd[i]  <= cfg_div;
                    modeShd[i] <= cfg_mode;
                end

                if (sync) begin
                    cnt[i]     <= CNT_ZERO;
                    clkReg[i]  <= 1'b0;
                    tickReg[i] <= 1'b0;
                    if (wrSel[i]) pend[i] <= 1'b1;
                end else if (atTc[i]) begin
                    // The TC itself is governed by the old settings; the shadow takes over after it.
                    cnt[i]     <= CNT_ZERO;
                    tickReg[i] <= 1'b1;
                    pend[i]    <= wrSel[i];
                    if (pend[i]) begin
                        divAct[i]  <= divShd[i];
                        modeAct[i] <= modeShd[i];
                    end
                    if (pend[i] && (modeShd[i] != modeAct[i]))
                        clkReg[i] <= 1'b0;
                    else
                        clkReg[i] <= modeAct[i] ? 1'b1 : ~clkReg[i];
                end else begin
                    if (en) cnt[i] <= cnt[i] + CNT_ONE;
                    tickReg[i] <= 1'b0;
                    if (modeAct[i]) clkReg[i] <= 1'b0;
                    if (wrSel[i]) pend[i] <= 1'b1;
                end
            end
        end
    end

    assign cfg_pend = pend;
    assign clk_out  = clkReg;
    assign tick     = tickReg;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog with NCH=2, DIV_DEFAULT=3 and an 8-bit counter;
// a cycle table covers reset/default/reprogram, hand sequences cover the corner cases.
module tb_clk_div_prog;

    localparam int NCH   = 2;
    localparam int CNT_W = 8;
    localparam int CH_W  = 2;

    logic             clk = 1'b0;
    logic             reset, en, sync, cfg_we, cfg_mode;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_div;
    logic [NCH-1:0]   cfg_pend, clk_out, tick;

    int passCnt = 0;
    int total   = 0;

    typedef struct {
        logic [3:0] ctl;     // {reset, en, sync, cfg_we}
        logic [1:0] ch;
        logic [7:0] div;
        logic       mode;
        logic [1:0] expTick;
        logic [1:0] expClk;
        logic [1:0] expPend;
    } vec_t;

    clk_div_prog #(
        .NCH(NCH), .CNT_W(CNT_W), .DIV_DEFAULT(3), .CH_W(CH_W)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .sync(sync),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_mode(cfg_mode),
        .cfg_pend(cfg_pend), .clk_out(clk_out), .tick(tick)
    );

    always #5 clk = ~clk;

    function automatic vec_t vec(input logic [3:0] ctl, input logic [1:0] ch,
                                 input logic [7:0] div, input logic mode,
                                 input logic [5:0] exp);
        vec_t v;
        v.ctl     = ctl;
        v.ch      = ch;
        v.div     = div;
        v.mode    = mode;
        v.expTick = exp[5:4];
        v.expClk  = exp[3:2];
        v.expPend = exp[1:0];
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            passCnt++;
    endtask

    // Apply one cycle of inputs, then sample just after the rising edge.
    task automatic drive(input logic [3:0] ctl, input logic [1:0] ch,
                         input logic [7:0] div, input logic mode);
        {reset, en, sync, cfg_we} = ctl;
        cfg_ch   = ch;
        cfg_div  = div;
        cfg_mode = mode;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(4'b0100, 2'd0, 8'd0, 1'b0);
    endtask

    task automatic tickClk(input string name, input logic [1:0] t, input logic [1:0] c);
        check({name, " tick"}, 32'(tick), 32'(t));
        check({name, " clk_out"}, 32'(clk_out), 32'(c));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[18];
        int   n;

        // Reset, default div=3 counting, then ch1 reprogrammed to div=1 while its cnt is 1.
        tbl[0]  = vec(4'b1000, 2'd0, 8'd0, 1'b0, 6'b00_00_00);
        tbl[1]  = vec(4'b1000, 2'd0, 8'd0, 1'b0, 6'b00_00_00);
        tbl[2]  = vec(4'b0100, 2'd0, 8'd0, 1'b0, 6'b00_00_00);
        tbl[3]  = vec(4'b0100, 2'd0, 8'd0, 1'b0, 6'b00_00_00);
        tbl[4]  = vec(4'b0100, 2'd0, 8'd0, 1'b0, 6'b00_00_00);
        tbl[5]  = vec(4'b0100, 2'd0, 8'd0, 1'b0, 6'b11_11_00);
        tbl[6]  = vec(4'b0100, 2'd0, 8'd0, 1'b0, 6'b00_11_00);
        tbl[7]  = vec(4'b0101, 2'd1, 8'd1, 1'b0, 6'b00_11_10);
        tbl[8]  = vec(4'b0100, 2'd0, 8'd0, 1'b0, 6'b00_11_10);
        tbl[9]  = vec(4'b0100, 2'd0, 8'd0, 1'b0, 6'b11_00_00);
        tbl[10] = vec(4'b0100, 2'd0, 8'd0, 1'b0, 6'b00_00_00);
        tbl[11] = vec(4'b0100, 2'd0, 8'd0, 1'b0, 6'b10_10_00);
        tbl[12] = vec(4'b0100, 2'd0, 8'd0, 1'b0, 6'b00_10_00);
        tbl[13] = vec(4'b0100, 2'd0, 8'd0, 1'b0, 6'b11_01_00);
        tbl[14] = vec(4'b0100, 2'd0, 8'd0, 1'b0, 6'b00_01_00);
        tbl[15] = vec(4'b0100, 2'd0, 8'd0, 1'b0, 6'b10_11_00);
        tbl[16] = vec(4'b0100, 2'd0, 8'd0, 1'b0, 6'b00_11_00);
        tbl[17] = vec(4'b0100, 2'd0, 8'd0, 1'b0, 6'b11_00_00);

        {reset, en, sync, cfg_we, cfg_mode} = '0;
        cfg_ch  = '0;
        cfg_div = '0;

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].ctl, tbl[i].ch, tbl[i].div, tbl[i].mode);
            check($sformatf("row%0d tick", i), 32'(tick), 32'(tbl[i].expTick));
            check($sformatf("row%0d clk_out", i), 32'(clk_out), 32'(tbl[i].expClk));
            check($sformatf("row%0d cfg_pend", i), 32'(cfg_pend), 32'(tbl[i].expPend));
        end

        // Pulse mode with div=0 on ch0: waits for the div=3 TC, then ticks every cycle.
        drive(4'b0101, 2'd0, 8'd0, 1'b1);
        check("pulse0 pend set", 32'(cfg_pend[0]), 32'd1);
        n = 0;
        while (cfg_pend[0] && n < 10) begin
            idle();
            n++;
        end
        check("pulse0 apply latency", 32'(n), 32'd3);
        check("pulse0 apply tick", 32'(tick[0]), 32'd1);
        for (int i = 0; i < 4; i++) begin
            idle();
            check($sformatf("div0 tick c%0d", i), 32'(tick[0]), 32'd1);
            check($sformatf("div0 clk c%0d", i), 32'(clk_out[0]), 32'd1);
        end

        // div=2 pulse: applied at the following TC, then one pulse every 3 cycles.
        drive(4'b0101, 2'd0, 8'd2, 1'b1);
        check("div2 pend set", 32'(cfg_pend[0]), 32'd1);
        idle();
        check("div2 pend clear", 32'(cfg_pend[0]), 32'd0);
        check("div2 apply tick", 32'(tick[0]), 32'd1);
        for (int j = 1; j <= 9; j++) begin
            idle();
            check($sformatf("div2 tick j%0d", j), 32'(tick[0]), 32'((j % 3) == 0));
            check($sformatf("div2 clk j%0d", j), 32'(clk_out[0]), 32'((j % 3) == 0));
        end

        // sync realign, then freeze with en=0 and resume from the held count.
        drive(4'b0110, 2'd0, 8'd0, 1'b0);
        tickClk("sync s0", 2'b00, 2'b00);
        idle();
        tickClk("sync s1", 2'b00, 2'b00);
        idle();
        tickClk("sync s2", 2'b10, 2'b10);
        for (int i = 0; i < 5; i++) begin
            drive(4'b0000, 2'd0, 8'd0, 1'b0);
            tickClk($sformatf("freeze f%0d", i), 2'b00, 2'b10);
        end
        idle();
        tickClk("resume r1", 2'b01, 2'b11);
        idle();
        tickClk("resume r2", 2'b10, 2'b00);
        idle();
        tickClk("resume r3", 2'b00, 2'b00);
        idle();
        tickClk("resume r4", 2'b11, 2'b11);

        // Write on the TC-apply cycle: pend stays set and the new div waits one more period.
        drive(4'b0110, 2'd0, 8'd0, 1'b0);
        drive(4'b0101, 2'd0, 8'd1, 1'b1);
        idle();
        drive(4'b0101, 2'd0, 8'd4, 1'b1);
        check("collide pend kept", 32'(cfg_pend[0]), 32'd1);
        check("collide tc", 32'(tick[0]), 32'd1);
        idle();
        check("collide c4 tick", 32'(tick[0]), 32'd0);
        idle();
        check("collide c5 tick", 32'(tick[0]), 32'd1);
        check("collide c5 pend", 32'(cfg_pend[0]), 32'd0);
        for (int i = 6; i <= 10; i++) begin
            idle();
            check($sformatf("div4 c%0d tick", i), 32'(tick[0]), 32'(i == 10));
        end

        // Two writes while pending: last one (div=0) wins.
        drive(4'b0101, 2'd0, 8'd3, 1'b1);
        drive(4'b0101, 2'd0, 8'd0, 1'b1);
        idle();
        check("lastwin d3 tick", 32'(tick[0]), 32'd0);
        idle();
        check("lastwin d4 tick", 32'(tick[0]), 32'd0);
        idle();
        check("lastwin d5 tick", 32'(tick[0]), 32'd1);
        check("lastwin d5 pend", 32'(cfg_pend[0]), 32'd0);
        idle();
        check("lastwin d6 tick", 32'(tick[0]), 32'd1);
        idle();
        check("lastwin d7 tick", 32'(tick[0]), 32'd1);

        // Out-of-range channel indices change nothing.
        drive(4'b0101, 2'd2, 8'd5, 1'b0);
        check("ch2 ignored pend", 32'(cfg_pend), 32'd0);
        drive(4'b0101, 2'd3, 8'd5, 1'b0);
        check("ch3 ignored pend", 32'(cfg_pend), 32'd0);
        idle();
        check("ch ignored tick0", 32'(tick[0]), 32'd1);

        // Reset mid-operation with ch1 pending and clk_out[1] high.
        drive(4'b0110, 2'd0, 8'd0, 1'b0);
        idle();
        idle();
        drive(4'b0101, 2'd1, 8'd7, 1'b0);
        check("prereset pend1", 32'(cfg_pend[1]), 32'd1);
        check("prereset clk1", 32'(clk_out[1]), 32'd1);
        drive(4'b1000, 2'd0, 8'd0, 1'b0);
        check("midreset pend", 32'(cfg_pend), 32'd0);
        tickClk("midreset", 2'b00, 2'b00);
        for (int i = 1; i <= 4; i++) begin
            idle();
            check($sformatf("postreset e%0d tick", i), 32'(tick), (i == 4) ? 32'd3 : 32'd0);
        end
        check("postreset clk_out", 32'(clk_out), 32'd3);

        $display("%0d/%0d checks passed", passCnt, total);
        $finish;
    end

endmodule
